spi_slave_burst: RTL and testbench

Parametrised SPI slave (mode 0) with configurable word width, MSB/LSB-first ordering, and multi-word burst transfers while cs_n is held low. A TX FIFO decouples the word producer from the shift timing. RX words are presented on a valid/ready interface. Underrun and overrun are detected and held in sticky flags. It replaces the fixed 8-bit single-word SPI block in the peripheral front-end.

---
 rtl/spi_slave_burst_pkg.sv | 34 +++
 rtl/spi_slave_burst_if.sv | 40 ++++
 rtl/spi_slave_burst_tx_fifo.sv | 68 ++++++
 rtl/spi_slave_burst.sv | 187 ++++++++++++++++++
 tb/tb_spi_slave_burst.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_burst_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_slave_burst_pkg
// Description : Shared definitions for the burst SPI slave: SPI mode
//               encoding and width helpers for bit indices and FIFO pointers.
// Contents    : spi_mode_e, SPI_MODE, idx_w(), ptr_w()
// Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_burst_pkg;

  // Only MODE0 (CPOL=0, CPHA=0) is implemented; the other encodings are
  // reserved so a later CPOL/CPHA extension keeps the same type.
  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_e;

  localparam spi_mode_e SPI_MODE = MODE0;

  // Width of a bit index counting 0..width-1.
  function automatic int idx_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  // Width of a FIFO address for a power-of-two depth (>= 2).
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_burst_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_slave_burst_if
// Description : Parallel-side bundle of the burst SPI slave: TX push
//               handshake, RX valid/ready handshake and status/error signals.
// Ports       : tx_data/tx_valid/tx_ready  - TX FIFO push
//               rx_data/rx_valid/rx_ready  - received word hand-off
//               word_cnt, busy             - burst progress
//               tx_underrun, rx_overrun    - sticky errors, err_clr clears
// Modports    : slave (the SPI block), master (the word producer/consumer)
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_burst_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [CNT_W-1:0] word_cnt;
  logic             tx_underrun;
  logic             rx_overrun;
  logic             err_clr;
  logic             busy;

  modport slave (
    input  tx_data, tx_valid, rx_ready, err_clr,
    output tx_ready, rx_data, rx_valid, word_cnt, tx_underrun, rx_overrun, busy
  );

  modport master (
    output tx_data, tx_valid, rx_ready, err_clr,
    input  tx_ready, rx_data, rx_valid, word_cnt, tx_underrun, rx_overrun, busy
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_burst_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_tx_fifo
// Description : DEPTH x WIDTH register FIFO feeding the SPI transmitter.
//               Push on posedge sclk, pop on negedge sclk.
// Ports       : sclk, rst_n (async, active-low)
//               push, push_data  - write request (ignored when full)
//               pop              - remove head (caller guarantees !empty)
//               head, empty, full
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_fifo
  import spi_slave_burst_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire              sclk,
  input  wire              rst_n,
  input  wire              push,
  input  wire  [WIDTH-1:0] push_data,
  input  wire              pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = ptr_w(DEPTH);

  // One extra pointer bit distinguishes full from empty. Each pointer is
  // owned by exactly one clock edge, so occupancy derived from their
  // difference is always consistent regardless of which edge moved last.
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign head      = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_push_ok = push && !full;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (w_push_ok) begin
      r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge sclk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= push_data;
    end
  end

  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
    end else if (pop && !empty) begin
      r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_slave_burst.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_slave_burst
// Description : SPI mode-0 slave with configurable word width and bit order,
//               multi-word bursts while cs_n is low, TX FIFO, RX valid/ready
//               hand-off and sticky underrun/overrun flags.
// Ports       : sclk             - SPI clock, only clock of the block
//               rst_n            - async active-low reset
//               cs_n, mosi, miso - SPI pins (miso is 1'bz while cs_n high)
//               bus              - spi_slave_burst_if.slave parallel side
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_burst
  import spi_slave_burst_pkg::*;
#(
  parameter int             WIDTH     = 8,
  parameter int             TX_DEPTH  = 4,
  parameter bit             MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] FILL    = '0,
  parameter int             CNT_W     = 8
) (
  input  wire               sclk,
  input  wire               rst_n,
  input  wire               cs_n,
  input  wire               mosi,
  output wire               miso,
  spi_slave_burst_if.slave  bus
);

  localparam int             IDX_W    = idx_w(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  // ---------------------------------------------------------------- TX FIFO
  logic [WIDTH-1:0] w_head;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;

  spi_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .push      (bus.tx_valid),
    .push_data (bus.tx_data),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full)
  );

  // ------------------------------------------------------------- state
  logic [WIDTH-2:0] r_rx_shift;   // the in-flight partial word needs one bit less than a word
  logic [IDX_W-1:0] r_rx_idx;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic [CNT_W-1:0] r_word_cnt;
  logic             r_rx_overrun;
  logic [IDX_W-1:0] r_tx_idx;
  logic [WIDTH-1:0] r_tx_shift;

  // The underrun flag is set on negedge but cleared on posedge. Each edge
  // owns one toggle bit and the flag is their XOR, so neither edge ever
  // writes the other's register.
  logic             r_udr_set_tgl;
  logic             r_udr_clr_tgl;
  logic             w_underrun;

  logic [WIDTH-1:0] w_rx_word;
  logic [WIDTH-2:0] w_rx_shift_nxt;
  logic [WIDTH-1:0] w_tx_src;
  logic [WIDTH-1:0] w_tx_src_shifted;
  logic [WIDTH-1:0] w_tx_shift_nxt;
  logic             w_tx_src_bit;
  logic             w_tx_shift_bit;
  logic             w_word_start;
  logic             w_tx_bit;

  assign w_underrun   = r_udr_set_tgl ^ r_udr_clr_tgl;
  assign w_word_start = (r_tx_idx == '0);
  assign w_tx_src     = w_empty ? FILL : w_head;
  assign w_pop        = !cs_n && w_word_start && !w_empty;

  // Bit-order dependent datapaths.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_rx_word        = {r_rx_shift, mosi};
      assign w_rx_shift_nxt   = w_rx_word[WIDTH-2:0];
      assign w_tx_src_bit     = w_tx_src[WIDTH-1];
      assign w_tx_src_shifted = {w_tx_src[WIDTH-2:0], 1'b0};
      assign w_tx_shift_bit   = r_tx_shift[WIDTH-1];
      assign w_tx_shift_nxt   = {r_tx_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_rx_word        = {mosi, r_rx_shift};
      assign w_rx_shift_nxt   = w_rx_word[WIDTH-1:1];
      assign w_tx_src_bit     = w_tx_src[0];
      assign w_tx_src_shifted = {1'b0, w_tx_src[WIDTH-1:1]};
      assign w_tx_shift_bit   = r_tx_shift[0];
      assign w_tx_shift_nxt   = {1'b0, r_tx_shift[WIDTH-1:1]};
    end
  endgenerate

  // Bit 0 of each word comes straight from the FIFO head so it is valid
  // from the cs_n fall, before the first sampling edge.
  assign w_tx_bit = w_word_start ? w_tx_src_bit : w_tx_shift_bit;
  assign miso     = cs_n ? 1'bz : w_tx_bit;

  // ------------------------------------------------------------- RX (posedge)
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_shift    <= '0;
      r_rx_idx      <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_word_cnt    <= '0;
      r_rx_overrun  <= 1'b0;
      r_udr_clr_tgl <= 1'b0;
    end else begin
      // Later assignments below override these, so a same-edge set wins
      // over err_clr and a same-edge completion keeps rx_valid high.
      if (r_rx_valid && bus.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      if (bus.err_clr) begin
        r_rx_overrun <= 1'b0;
        if (w_underrun) begin
          r_udr_clr_tgl <= ~r_udr_clr_tgl;
        end
      end

      if (cs_n) begin
        r_rx_idx   <= '0;
        r_word_cnt <= '0;
      end else begin
        r_rx_shift <= w_rx_shift_nxt;
        if (r_rx_idx == LAST_IDX) begin
          r_rx_idx <= '0;
          if (r_word_cnt != '1) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
          end
          if (r_rx_valid && !bus.rx_ready) begin
            r_rx_overrun <= 1'b1;
          end else begin
            r_rx_data  <= w_rx_word;
            r_rx_valid <= 1'b1;
          end
        end else begin
          r_rx_idx <= r_rx_idx + IDX_W'(1);
        end
      end
    end
  end

  // ------------------------------------------------------------- TX (negedge)
  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_idx      <= '0;
      r_tx_shift    <= '0;
      r_udr_set_tgl <= 1'b0;
    end else if (cs_n) begin
      // A word already popped is intentionally not re-queued.
      r_tx_idx <= '0;
    end else if (w_word_start) begin
      r_tx_shift <= w_tx_src_shifted;
      r_tx_idx   <= IDX_W'(1);
      if (w_empty && !w_underrun) begin
        r_udr_set_tgl <= ~r_udr_set_tgl;
      end
    end else begin
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_idx   <= (r_tx_idx == LAST_IDX) ? '0 : r_tx_idx + IDX_W'(1);
    end
  end

  // ------------------------------------------------------------- outputs
  assign bus.tx_ready    = !w_full;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.word_cnt    = r_word_cnt;
  assign bus.tx_underrun = w_underrun;
  assign bus.rx_overrun  = r_rx_overrun;
  assign bus.busy        = !cs_n && (r_rx_idx != '0);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_burst.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_burst
// Description : Self-checking bench. Two slaves share sclk/cs_n/mosi and the
//               TX/RX stimulus: dut_a is MSB-first with FILL=0xFF and an
//               8-bit word counter, dut_b is LSB-first with FILL=0x00 and a
//               3-bit word counter. A word-level reference model queues the
//               expected miso bits and received words; a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_burst;

  localparam int         W       = 8;
  localparam int         DEPTH   = 4;
  localparam logic [7:0] FILL_A  = 8'hFF;
  localparam logic [7:0] FILL_B  = 8'h00;
  localparam int         CNT_A   = 8;
  localparam int         CNT_B   = 3;
  localparam int         SAT_A   = 255;
  localparam int         SAT_B   = 7;

  logic sclk  = 1'b0;
  logic rst_n = 1'b0;
  logic cs_n  = 1'b1;
  logic mosi  = 1'b0;
  wire  miso_a;
  wire  miso_b;

  spi_slave_burst_if #(.WIDTH(W), .CNT_W(CNT_A)) bus_a ();
  spi_slave_burst_if #(.WIDTH(W), .CNT_W(CNT_B)) bus_b ();

  spi_slave_burst #(
    .WIDTH(W), .TX_DEPTH(DEPTH), .MSB_FIRST(1'b1), .FILL(FILL_A), .CNT_W(CNT_A)
  ) dut_a (
    .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .mosi(mosi), .miso(miso_a), .bus(bus_a.slave)
  );

  spi_slave_burst #(
    .WIDTH(W), .TX_DEPTH(DEPTH), .MSB_FIRST(1'b0), .FILL(FILL_B), .CNT_W(CNT_B)
  ) dut_b (
    .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .mosi(mosi), .miso(miso_b), .bus(bus_b.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------------------------------------------------- reference model
  logic [7:0]  m_fifo[$];     // words queued for transmission
  logic [1:0]  m_miso_q[$];   // {dut_a bit, dut_b bit} per SPI bit
  logic [15:0] m_rx_q[$];     // {dut_a word, dut_b word} awaiting hand-off
  logic [7:0]  m_rx;          // mosi bits of the current word, first bit oldest
  int          m_bitpos;
  int          m_cnt;
  bit          m_valid, m_udr, m_ovr;
  logic [7:0]  stim[$];       // mosi words of the next burst (first bit = word[7])
  event        ev_pre;

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete(); m_miso_q.delete(); m_rx_q.delete();
    m_rx = '0; m_bitpos = 0; m_cnt = 0;
    m_valid = 0; m_udr = 0; m_ovr = 0;
  endtask

  // Effect of the coming sclk period given the inputs now applied.
  task automatic model_pre();
    logic [7:0] wa, wb, fa, fb, rw;
    bit rr;
    fa = FILL_A; fb = FILL_B;
    rr = bus_a.rx_ready;
    if (bus_a.err_clr) begin m_udr = 0; m_ovr = 0; end
    if (!cs_n) begin
      if (m_bitpos == 0) begin
        if (m_fifo.size() == 0) begin
          m_udr = 1; wa = fa; wb = fb;
          for (int k = 0; k < 8; k++) m_miso_q.push_back({wa[7-k], wb[k]});
        end else begin
          wa = m_fifo.pop_front();
          for (int k = 0; k < 8; k++) m_miso_q.push_back({wa[7-k], wa[k]});
        end
      end
      m_rx = {m_rx[6:0], mosi};
      m_bitpos++;
      if (m_bitpos == 8) begin
        m_bitpos = 0;
        m_cnt++;
        rw = m_rx;
        if (m_valid && !rr) m_ovr = 1;
        else begin m_rx_q.push_back({rw, rev8(rw)}); m_valid = 1; end
      end else if (rr) m_valid = 0;
    end else begin
      m_bitpos = 0; m_cnt = 0;
      m_miso_q.delete();          // rest of an aborted word is never sent
      if (rr) m_valid = 0;
    end
    if (bus_a.tx_valid) begin
      chk("tx_ready_a@push", bus_a.tx_ready, m_fifo.size() < DEPTH);
      chk("tx_ready_b@push", bus_b.tx_ready, m_fifo.size() < DEPTH);
      if (m_fifo.size() < DEPTH) m_fifo.push_back(bus_a.tx_data);
    end
  endtask

  // ---------------------------------------------------------- monitor
  initial begin
    logic [1:0]  eb;
    logic [15:0] ew;
    forever begin
      @(ev_pre);
      if (!cs_n) begin
        if (m_miso_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL miso_expect: got unexpected bit expected none queued");
        end else begin
          eb = m_miso_q.pop_front();
          chk("miso_a", miso_a, eb[1]);
          chk("miso_b", miso_b, eb[0]);
        end
      end
      if (bus_a.rx_valid && bus_a.rx_ready) begin
        if (m_rx_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rx_word: got 0x%0h expected no word", bus_a.rx_data);
        end else begin
          ew = m_rx_q.pop_front();
          chk("rx_data_a", bus_a.rx_data, ew[15:8]);
          chk("rx_data_b", bus_b.rx_data, ew[7:0]);
          chk("rx_valid_b", bus_b.rx_valid, 1'b1);
        end
      end
    end
  end

  // ---------------------------------------------------------- driver
  task automatic tick(input bit cs, input bit mo, input bit tv, input logic [7:0] td,
                      input bit rr, input bit ec);
    #1;
    cs_n = cs; mosi = mo;
    bus_a.tx_valid = tv; bus_b.tx_valid = tv;
    bus_a.tx_data  = td; bus_b.tx_data  = td;
    bus_a.rx_ready = rr; bus_b.rx_ready = rr;
    bus_a.err_clr  = ec; bus_b.err_clr  = ec;
    #1 model_pre();
    #2 -> ev_pre;
    #1 sclk = 1'b1;
    #5 sclk = 1'b0;
    #1;
  endtask

  task automatic idle(input int n, input bit ec);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 8'h00, 1, ec);
  endtask

  task automatic push(input logic [7:0] d);
    tick(1, 0, 1, d, 1, 0);
  endtask

  // rr_mode: 0 = rx_ready low, 1 = high, 2 = random
  task automatic burst(input int nbits, input int rr_mode);
    logic [7:0] w;
    bit rr;
    for (int i = 0; i < nbits; i++) begin
      w  = stim[i/8];
      rr = (rr_mode == 2) ? ($urandom_range(0, 3) != 0) : (rr_mode == 1);
      tick(0, w[7 - (i % 8)], 0, 8'h00, rr, 0);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "/word_cnt_a"}, 32'(bus_a.word_cnt), sat(m_cnt, SAT_A));
    chk({tag, "/word_cnt_b"}, 32'(bus_b.word_cnt), sat(m_cnt, SAT_B));
    chk({tag, "/underrun_a"}, bus_a.tx_underrun, m_udr);
    chk({tag, "/underrun_b"}, bus_b.tx_underrun, m_udr);
    chk({tag, "/overrun_a"},  bus_a.rx_overrun,  m_ovr);
    chk({tag, "/overrun_b"},  bus_b.rx_overrun,  m_ovr);
    chk({tag, "/rx_valid_a"}, bus_a.rx_valid,    m_valid);
    chk({tag, "/tx_ready_a"}, bus_a.tx_ready,    m_fifo.size() < DEPTH);
    chk({tag, "/busy_a"},     bus_a.busy,        !cs_n && (m_bitpos != 0));
    chk({tag, "/busy_b"},     bus_b.busy,        !cs_n && (m_bitpos != 0));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "/rx_data_a"},  bus_a.rx_data, 8'h00);
    chk({tag, "/rx_valid_a"}, bus_a.rx_valid, 1'b0);
    chk({tag, "/tx_ready_a"}, bus_a.tx_ready, 1'b1);
    chk({tag, "/word_cnt_a"}, 32'(bus_a.word_cnt), 0);
    chk({tag, "/underrun_a"}, bus_a.tx_underrun, 1'b0);
    chk({tag, "/overrun_a"},  bus_a.rx_overrun, 1'b0);
    chk({tag, "/busy_a"},     bus_a.busy, 1'b0);
    chk({tag, "/rx_valid_b"}, bus_b.rx_valid, 1'b0);
    chk({tag, "/word_cnt_b"}, 32'(bus_b.word_cnt), 0);
  endtask

  initial begin
    int nw;
    bus_a.tx_valid = 0; bus_b.tx_valid = 0;
    bus_a.tx_data  = 0; bus_b.tx_data  = 0;
    bus_a.rx_ready = 1; bus_b.rx_ready = 1;
    bus_a.err_clr  = 0; bus_b.err_clr  = 0;
    model_reset();
    #3 check_reset_values("reset");
    #2 rst_n = 1'b1;
    idle(2, 0);

    // Two-word MSB-first burst (LSB-first view on dut_b)
    push(8'hA5); push(8'h3C);
    stim = '{8'h5A, 8'hC3};
    burst(16, 1);
    check_status("two_word");
    idle(2, 0);

    // Single word 0x01 (dut_b receives it LSB-first as 0x80)
    push(8'h01);
    stim = '{8'h01};
    burst(8, 1);
    idle(1, 0);
    check_status("single_word");

    // Empty FIFO -> FILL and underrun, then err_clr
    stim = '{8'h96};
    burst(8, 1);
    check_status("underrun_set");
    idle(1, 1);
    check_status("underrun_clr");

    // rx_ready low across three words -> overrun, first word kept
    push(8'h11); push(8'h22); push(8'h33);
    stim = '{8'hE1, 8'h72, 8'h0F};
    burst(24, 0);
    check_status("overrun_set");
    idle(2, 0);
    idle(1, 1);
    check_status("overrun_clr");

    // Five pushes into a four-deep FIFO; the fifth is dropped
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    check_status("fifo_full");
    stim = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    burst(40, 1);
    check_status("fifo_drain");
    idle(1, 1);

    // Abort after three bits; popped word is lost, next burst sends the next head
    push(8'hC6); push(8'h39);
    stim = '{8'hFF};
    burst(3, 1);
    check_status("abort_mid");
    idle(1, 0);
    check_status("abort_after");
    stim = '{8'h5C};
    burst(8, 1);
    idle(1, 0);
    check_status("after_abort_burst");

    // Randomised bursts (longer than 7 words saturate dut_b's counter)
    for (int it = 0; it < 25; it++) begin
      nw = $urandom_range(0, 5);
      for (int i = 0; i < nw; i++) push(8'($urandom));
      nw = $urandom_range(1, 10);
      stim.delete();
      for (int i = 0; i < nw; i++) stim.push_back(8'($urandom));
      if ($urandom_range(0, 4) == 0) burst($urandom_range(1, 8 * nw - 1), 2);
      else                           burst(8 * nw, 2);
      check_status("random_burst");
      idle(1, 0);
      idle(1, $urandom_range(0, 1));
    end
    idle(2, 1);
    check_status("random_end");

    // Asynchronous reset in the middle of a word
    push(8'hAA); push(8'h55);
    stim = '{8'h3A};
    burst(4, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    model_reset();
    cs_n = 1'b1;
    #1 rst_n = 1'b1;
    idle(2, 0);
    check_status("post_reset");

    chk("rx_queue_drained", m_rx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog: the run is a fixed sequence of ticks, so this only fires if
  // the bench itself stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
